// File: rtl/lbp_hist.sv
`default_nettype none
// ============================================================================
// Module      : lbp_hist
// Description : Rotation-invariant uniform (riu2) LBP histogram over the 6x6
//               interior of an 8x8 block. Ten bins are drained through a
//               valid/ready port. Define LBP_HIST_SAT_EN to saturate the
//               counters at 63; when it is left undefined they wrap modulo 64.
// Revision    : 1.0 - initial release
// ============================================================================
module lbp_hist (
    input  logic       clk,
    input  logic       reset,
    input  logic       lbp_write,
    input  logic [5:0] lbp_addr,
    input  logic [7:0] lbp_data,
    input  logic       finish,
    output logic       hist_valid,
    input  logic       hist_ready,
    output logic [3:0] hist_bin,
    output logic [5:0] hist_count,
    output logic       hist_last,
    output logic       done
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ACC   = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    localparam int         NUM_BINS = 10;
    localparam logic [3:0] LAST_BIN = 4'd9;

    // Bin = popcount for uniform patterns (<= 2 circular transitions), else 9.
    function automatic logic [3:0] riu2_bin(input logic [7:0] d);
        logic [7:0] t;
        logic [3:0] u;
        logic [3:0] p;
        t = d ^ {d[6:0], d[7]};
        u = 4'd0;
        p = 4'd0;
        for (int i = 0; i < 8; i++) begin
            u = u + {3'b000, t[i]};
            p = p + {3'b000, d[i]};
        end
        return (u <= 4'd2) ? p : LAST_BIN;
    endfunction

    logic [1:0] state_q, state_d;
    logic [3:0] bin_q, bin_d;
    logic [5:0] cnt_q [NUM_BINS];
    logic [5:0] cnt_d [NUM_BINS];

    logic [2:0] row, col;
    logic       interior;
    logic       hit;
    logic [3:0] hit_bin;
    logic       accept;

    assign row      = lbp_addr[5:3];
    assign col      = lbp_addr[2:0];
    assign interior = (row >= 3'd1) && (row <= 3'd6) && (col >= 3'd1) && (col <= 3'd6);
    assign hit      = lbp_write && interior && ((state_q == S_IDLE) || (state_q == S_ACC));
    assign hit_bin  = riu2_bin(lbp_data);
    assign accept   = (state_q == S_DRAIN) && hist_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            bin_q   <= 4'd0;
            for (int i = 0; i < NUM_BINS; i++) cnt_q[i] <= 6'd0;
        end else begin
            state_q <= state_d;
            bin_q   <= bin_d;
            for (int i = 0; i < NUM_BINS; i++) cnt_q[i] <= cnt_d[i];
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (finish)   state_d = S_DRAIN;
                else if (hit) state_d = S_ACC;
            end
            S_ACC:   if (finish) state_d = S_DRAIN;
            S_DRAIN: if (accept && (bin_q == LAST_BIN)) state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // bin_q returns to 0 on the final accept so the next drain starts at bin 0.
    always_comb begin
        bin_d = bin_q;
        if (accept) bin_d = (bin_q == LAST_BIN) ? 4'd0 : bin_q + 4'd1;
    end

    always_comb begin
        for (int i = 0; i < NUM_BINS; i++) begin
            cnt_d[i] = cnt_q[i];
            if (state_q == S_DONE) begin
                cnt_d[i] = 6'd0;
            end else if (hit && (hit_bin == 4'(i))) begin
`ifdef LBP_HIST_SAT_EN
                cnt_d[i] = (cnt_q[i] == 6'd63) ? 6'd63 : cnt_q[i] + 6'd1;
`else
                cnt_d[i] = cnt_q[i] + 6'd1;
`endif
            end
        end
    end

    always_comb begin
        hist_valid = (state_q == S_DRAIN);
        hist_last  = (state_q == S_DRAIN) && (bin_q == LAST_BIN);
        done       = (state_q == S_DONE);
        hist_bin   = 4'd0;
        hist_count = 6'd0;
        if (state_q == S_DRAIN) begin
            hist_bin = bin_q;
            for (int i = 0; i < NUM_BINS; i++) begin
                if (bin_q == 4'(i)) hist_count = cnt_q[i];
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_lbp_hist.sv
`default_nettype none
// ============================================================================
// Module      : tb_lbp_hist
// Description : Directed self-checking bench for lbp_hist with hand-computed
//               bin expectations.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_lbp_hist;

    logic       clk;
    logic       reset;
    logic       lbp_write;
    logic [5:0] lbp_addr;
    logic [7:0] lbp_data;
    logic       finish;
    logic       hist_valid;
    logic       hist_ready;
    logic [3:0] hist_bin;
    logic [5:0] hist_count;
    logic       hist_last;
    logic       done;

    int total;
    int bad;
    int exp_cnt [10];

    lbp_hist dut (
        .clk        (clk),
        .reset      (reset),
        .lbp_write  (lbp_write),
        .lbp_addr   (lbp_addr),
        .lbp_data   (lbp_data),
        .finish     (finish),
        .hist_valid (hist_valid),
        .hist_ready (hist_ready),
        .hist_bin   (hist_bin),
        .hist_count (hist_count),
        .hist_last  (hist_last),
        .done       (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int want);
        total++;
        if (got != want) begin
            bad++;
            $display("FAIL %s: got=%0d expected=%0d (t=%0t)", tag, got, want, $time);
        end
    endtask

    task automatic clear_exp();
        for (int i = 0; i < 10; i++) exp_cnt[i] = 0;
    endtask

    // All drives happen just after a falling edge.
    task automatic wr(input int addr, input logic [7:0] data);
        lbp_write = 1'b1;
        lbp_addr  = 6'(addr);
        lbp_data  = data;
        @(negedge clk);
        lbp_write = 1'b0;
    endtask

    task automatic wr_fin(input int addr, input logic [7:0] data);
        lbp_write = 1'b1;
        lbp_addr  = 6'(addr);
        lbp_data  = data;
        finish    = 1'b1;
        @(negedge clk);
        lbp_write = 1'b0;
        finish    = 1'b0;
    endtask

    task automatic fin();
        finish = 1'b1;
        @(negedge clk);
        finish = 1'b0;
    endtask

    // Walk the drain; stop_at < 10 returns while that bin is presented.
    task automatic drain(input bit toggle, input int stop_at);
        int b;
        int p;
        int cyc;
        b = 0;
        p = 0;
        cyc = 0;
        while (b < 10 && cyc < 100) begin
            if (b == stop_at) begin
                hist_ready = 1'b0;
                check("stop_bin", int'(hist_bin), b);
                return;
            end
            hist_ready = toggle ? ((p % 4 == 0) || (p % 4 == 3)) : 1'b1;
            p++;
            check("valid", int'(hist_valid), 1);
            check("bin", int'(hist_bin), b);
            check("count", int'(hist_count), exp_cnt[b]);
            check("last", int'(hist_last), (b == 9) ? 1 : 0);
            check("done_in_drain", int'(done), 0);
            if (hist_ready && hist_valid) b++;
            @(negedge clk);
            cyc++;
        end
        if (b < 10) check("drain_timeout", b, 10);
        check("done_pulse", int'(done), 1);
        check("valid_in_done", int'(hist_valid), 0);
        check("last_in_done", int'(hist_last), 0);
        hist_ready = 1'b0;
        @(negedge clk);
        check("done_one_cycle", int'(done), 0);
        check("valid_after_done", int'(hist_valid), 0);
    endtask

    initial begin
        total      = 0;
        bad        = 0;
        reset      = 1'b1;
        lbp_write  = 1'b0;
        lbp_addr   = 6'd0;
        lbp_data   = 8'd0;
        finish     = 1'b0;
        hist_ready = 1'b0;
        clear_exp();

        // Reset state, with write and finish also asserted to test priority.
        @(negedge clk);
        lbp_write = 1'b1;
        lbp_addr  = 6'd9;
        finish    = 1'b1;
        @(negedge clk);
        lbp_write = 1'b0;
        finish    = 1'b0;
        check("rst_valid", int'(hist_valid), 0);
        check("rst_last", int'(hist_last), 0);
        check("rst_done", int'(done), 0);
        check("rst_bin", int'(hist_bin), 0);
        check("rst_count", int'(hist_count), 0);
        reset = 1'b0;
        @(negedge clk);
        check("idle_valid", int'(hist_valid), 0);

        // Mixed codes; last write shares its cycle with finish.
        wr(9, 8'h00);
        wr(10, 8'hFF);
        wr(11, 8'h0F);
        check("acc_valid", int'(hist_valid), 0);
        wr_fin(12, 8'h55);
        clear_exp();
        exp_cnt[0] = 1; exp_cnt[4] = 1; exp_cnt[8] = 1; exp_cnt[9] = 1;
        drain(1'b0, 10);

        // Full interior frame of 0x01, drained with ready toggling 1,0,0,1.
        for (int r = 1; r <= 6; r++)
            for (int c = 1; c <= 6; c++)
                wr(r * 8 + c, 8'h01);
        fin();
        // Writes and finish during drain must be ignored.
        lbp_write = 1'b1;
        lbp_addr  = 6'd9;
        lbp_data  = 8'h01;
        clear_exp();
        exp_cnt[1] = 36;
        drain(1'b1, 10);
        lbp_write = 1'b0;

        // Border addresses only: finish with nothing counted drains zeros.
        wr(0, 8'h00);
        wr(7, 8'h00);
        wr(56, 8'h00);
        wr(63, 8'h00);
        wr(8, 8'h00);
        wr(15, 8'h00);
        fin();
        clear_exp();
        drain(1'b0, 10);

        // 70 hits on bin 0.
        for (int i = 0; i < 70; i++) wr(9, 8'h00);
        fin();
        clear_exp();
`ifdef LBP_HIST_SAT_EN
        exp_cnt[0] = 63;
`else
        exp_cnt[0] = 6;
`endif
        drain(1'b0, 10);

        // Reset while bin 4 is presented.
        wr(9, 8'h00);
        wr(10, 8'h00);
        wr(11, 8'h00);
        wr(12, 8'h0F);
        fin();
        clear_exp();
        exp_cnt[0] = 3; exp_cnt[4] = 1;
        drain(1'b0, 4);
        check("bin4_count_pre_rst", int'(hist_count), 1);
        reset = 1'b1;
        @(negedge clk);
        check("abort_valid", int'(hist_valid), 0);
        check("abort_done", int'(done), 0);
        check("abort_count", int'(hist_count), 0);
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("abort_no_done", int'(done), 0);
            check("abort_no_valid", int'(hist_valid), 0);
        end

        // Fresh frame must start from zero counts.
        wr(20, 8'hFF);
        fin();
        clear_exp();
        exp_cnt[8] = 1;
        drain(1'b0, 10);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
